// File: rtl/fpu_regfile_sb.sv
// -----------------------------------------------------------------------------
// fpu_regfile_sb
// Parametrised FP register file with a per-register pending-write scoreboard.
// Multi-cycle FPU ops mark their destination busy at issue; readers see
// rbusy/stall until the retiring writeback arrives (which is forwarded
// through to the read data in the same cycle).
//
// Optional feature: define FPU_RF_STALL_STATS_EN to build a saturating
// 32-bit stall-cycle counter on stall_cnt; otherwise stall_cnt is tied to 0.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   synchronous active-low reset
//   rden       in   [RPORTS]       read enable per port
//   raddr      in   [RPORTS*AW]    read addresses, port i at [i*AW +: AW]
//   rdata      out  [RPORTS*FLEN]  read data (0 when rden=0), write-through
//   rbusy      out  [RPORTS]       read target has an outstanding write
//   stall      out                 any enabled read port is busy
//   wren       in   [WPORTS]       writeback enables (higher index wins)
//   waddr      in   [WPORTS*AW]    writeback addresses
//   wdata      in   [WPORTS*FLEN]  writeback data
//   wpend      in   [WPORTS]       writeback retires a scoreboard entry
//   iss_valid  in                  issue of an op writing iss_addr later
//   iss_addr   in   [AW]           destination of the issued op
//   iss_ready  out                 destination counter below MAX_PEND
//   flush      in                  clear all scoreboard counters
//   sb_err     out                 sticky scoreboard error (reset only)
//   stall_cnt  out  [32]           stall-cycle statistics
// -----------------------------------------------------------------------------
module fpu_regfile_sb #(
   parameter int FLEN     = 32,
   parameter int NREG     = 32,
   parameter int RPORTS   = 3,
   parameter int WPORTS   = 2,
   parameter int MAX_PEND = 3,
   localparam int AW      = $clog2(NREG),
   localparam int CW      = $clog2(MAX_PEND + 1)
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [RPORTS-1:0]        rden,
   input  logic [RPORTS*AW-1:0]     raddr,
   output logic [RPORTS*FLEN-1:0]   rdata,
   output logic [RPORTS-1:0]        rbusy,
   output logic                     stall,
   input  logic [WPORTS-1:0]        wren,
   input  logic [WPORTS*AW-1:0]     waddr,
   input  logic [WPORTS*FLEN-1:0]   wdata,
   input  logic [WPORTS-1:0]        wpend,
   input  logic                     iss_valid,
   input  logic [AW-1:0]            iss_addr,
   output logic                     iss_ready,
   input  logic                     flush,
   output logic                     sb_err,
   output logic [31:0]              stall_cnt
);

   logic [FLEN-1:0]          mem_r      [NREG];
   logic [CW-1:0]            pend_r     [NREG];
   logic [CW-1:0]            pend_nxt_s [NREG];
   logic [NREG-1:0]          ret_hit_s;
   logic [NREG-1:0]          ret_multi_s;
   logic                     err_set_s;
   logic                     sb_err_r;
   logic                     iss_ready_s;
   logic [RPORTS*FLEN-1:0]   rdata_s;
   logic [RPORTS-1:0]        rbusy_s;
   logic                     stall_s;

   // Admission check: the destination counter must have headroom.
   assign iss_ready_s = (pend_r[iss_addr] < CW'(MAX_PEND));

   // Per-register retire detection: any retiring port, and more than one.
   always_comb begin
      ret_hit_s   = {NREG{1'b0}};
      ret_multi_s = {NREG{1'b0}};
      for (int r = 0; r < NREG; r++) begin
         for (int j = 0; j < WPORTS; j++) begin
            if (wren[j] && wpend[j] && (waddr[j*AW +: AW] == AW'(r))) begin
               if (ret_hit_s[r]) begin
                  ret_multi_s[r] = 1'b1;
               end else begin
                  ret_multi_s[r] = ret_multi_s[r];
               end
               ret_hit_s[r] = 1'b1;
            end else begin
               ret_hit_s[r] = ret_hit_s[r];
            end
         end
      end
   end

   // Scoreboard next state and error detection. Retires are collapsed to a
   // single decrement; an underflow holds the counter at 0 and flags an error.
   always_comb begin
      err_set_s = 1'b0;
      for (int r = 0; r < NREG; r++) begin
         pend_nxt_s[r] = pend_r[r];
         if (flush) begin
            pend_nxt_s[r] = {CW{1'b0}};
         end else begin
            if (ret_multi_s[r]) begin
               err_set_s = 1'b1;
            end else begin
               err_set_s = err_set_s;
            end
            if (iss_valid && iss_ready_s && (iss_addr == AW'(r))) begin
               if (ret_hit_s[r]) begin
                  pend_nxt_s[r] = pend_r[r];
               end else begin
                  pend_nxt_s[r] = pend_r[r] + CW'(1);
               end
            end else if (ret_hit_s[r]) begin
               if (pend_r[r] == {CW{1'b0}}) begin
                  err_set_s = 1'b1;
               end else begin
                  pend_nxt_s[r] = pend_r[r] - CW'(1);
               end
            end else begin
               pend_nxt_s[r] = pend_r[r];
            end
         end
      end
   end

   // Read ports: write-through from the highest matching write port, and a
   // busy flag that drops when the last outstanding write retires this cycle.
   always_comb begin
      rdata_s = {(RPORTS*FLEN){1'b0}};
      rbusy_s = {RPORTS{1'b0}};
      for (int i = 0; i < RPORTS; i++) begin
         if (rden[i]) begin
            rdata_s[i*FLEN +: FLEN] = mem_r[raddr[i*AW +: AW]];
            for (int j = 0; j < WPORTS; j++) begin
               if (wren[j] && (waddr[j*AW +: AW] == raddr[i*AW +: AW])) begin
                  rdata_s[i*FLEN +: FLEN] = wdata[j*FLEN +: FLEN];
               end else begin
                  rdata_s[i*FLEN +: FLEN] = rdata_s[i*FLEN +: FLEN];
               end
            end
         end else begin
            rdata_s[i*FLEN +: FLEN] = {FLEN{1'b0}};
         end
         rbusy_s[i] = (pend_r[raddr[i*AW +: AW]] != {CW{1'b0}}) &&
                      !((pend_r[raddr[i*AW +: AW]] == CW'(1)) &&
                        ret_hit_s[raddr[i*AW +: AW]]);
      end
   end

   assign stall_s   = |(rden & rbusy_s);
   assign rdata     = rdata_s;
   assign rbusy     = rbusy_s;
   assign stall     = stall_s;
   assign iss_ready = iss_ready_s;
   assign sb_err    = sb_err_r;

   // Register array, scoreboard counters and sticky error flag.
   // Writes land in ascending port order so the highest port wins.
   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int r = 0; r < NREG; r++) begin
            mem_r[r]  <= {FLEN{1'b0}};
            pend_r[r] <= {CW{1'b0}};
         end
         sb_err_r <= 1'b0;
      end else begin
         for (int j = 0; j < WPORTS; j++) begin
            if (wren[j]) begin
               mem_r[waddr[j*AW +: AW]] <= wdata[j*FLEN +: FLEN];
            end
         end
         for (int r = 0; r < NREG; r++) begin
            pend_r[r] <= pend_nxt_s[r];
         end
         sb_err_r <= sb_err_r | err_set_s;
      end
   end

`ifdef FPU_RF_STALL_STATS_EN
   logic [31:0] stall_cnt_r;

   // Saturating stall-cycle counter; survives flush, cleared by reset only.
   always_ff @(posedge clock) begin
      if (!reset) begin
         stall_cnt_r <= 32'd0;
      end else if (stall_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
         stall_cnt_r <= stall_cnt_r + 32'd1;
      end
   end

   assign stall_cnt = stall_cnt_r;
`else
   assign stall_cnt = 32'd0;
`endif

endmodule
